// File: rtl/read_submodule.sv
// Single-transaction read initiator: one AR beat, one R beat, then a one-cycle done pulse.
// Optional watchdog enabled by defining READ_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module read_submodule #(
    parameter int ADDR_WDTH      = 32,
    parameter int DATA_WDTH      = 32,
    parameter int RESP_WDTH      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_address,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp,
    input  logic                 start,
    input  logic [ADDR_WDTH-1:0] addr,
    output logic [DATA_WDTH-1:0] data,
    output logic [RESP_WDTH-1:0] resp,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t state, next_state;
    logic   ar_hs, r_hs, timeout;

    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;

`ifdef READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // The limit cycle is the one in which cnt shows TIMEOUT_CYCLES-1; an R handshake there still wins.
    assign timeout = ((state == ADDR) || (state == DATA)) &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !r_hs;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if ((state == IDLE) && start)
            cnt <= '0;
        else if ((state == ADDR) || (state == DATA))
            cnt <= cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: next_state is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = ADDR;
            ADDR: begin
                if (timeout)    next_state = DONE;
                else if (ar_hs) next_state = DATA;
            end
            DATA: if (r_hs || timeout) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered by decoding next_state, so they line up with the state they describe.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ar_address <= '0;
            data       <= '0;
            resp       <= '0;
        end else begin
            state    <= next_state;
            ar_valid <= (next_state == ADDR);
            r_ready  <= (next_state == DATA);
            done     <= (next_state == DONE);
            busy     <= (next_state == ADDR) || (next_state == DATA);
            if ((state == IDLE) && start)
                ar_address <= addr;
            if (r_hs) begin
                data <= r_data;
                resp <= r_resp;
            end else if (timeout) begin
                data <= '0;
                resp <= '1;
            end
        end
    end

endmodule

// File: tb/tb_read_submodule.sv
// Scoreboard bench for read_submodule: the driver queues expected results, a negedge monitor checks them.
// Define READ_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_read_submodule;

`ifdef READ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic        clk, rst_n;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_address;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        start;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        done, busy;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] arq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_resp = '0;

    read_submodule #(
        .ADDR_WDTH(32), .DATA_WDTH(32), .RESP_WDTH(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .start(start), .addr(addr),
        .data(data), .resp(resp), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and every AR handshake.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ea;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rd_data", data, e.data);
                check("rd_resp", resp, e.resp);
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (rst_n === 1'b1 && ar_valid === 1'b1 && ar_ready === 1'b1) begin
            if (arq.size() == 0) begin
                check("unexpected_ar", 1, 0);
            end else begin
                ea = arq.pop_front();
                check("ar_address", ar_address, ea);
            end
        end
    end

    // One read: aw cycles of ar_ready stall, rw cycles of r_valid stall; poke issues a stray start in DATA.
    task automatic do_read(input logic [31:0] a, input int aw, input int rw,
                           input logic [31:0] d, input logic [1:0] rs, input bit poke);
        int   s;
        exp_t e;
        @(posedge clk); #1;
        s = cyc + 1;
        e.data = d; e.resp = rs; e.cyc = s + 2 + aw + rw;
        sb.push_back(e);
        arq.push_back(a);
        start = 1'b1; addr = a; ar_ready = (aw == 0); r_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; addr = '0;
        if (aw > 0) begin
            r_valid = 1'b1; r_data = 32'hBAD0_BAD0; r_resp = 2'b01;
        end
        for (int i = 0; i <= aw; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("hold_data", data, last_data);
                check("hold_resp", resp, last_resp);
            end
            check("ar_valid_addr", ar_valid, 1);
            check("ar_addr_stable", ar_address, a);
            check("busy_addr", busy, 1);
            @(posedge clk); #1;
            if (i == aw - 1) ar_ready = 1'b1;
        end
        ar_ready = 1'b0;
        r_valid = (rw == 0); r_data = d; r_resp = rs;
        if (poke) begin
            start = 1'b1; addr = 32'h80;
        end
        for (int i = 0; i <= rw; i++) begin
            @(negedge clk);
            check("r_ready_data", r_ready, 1);
            check("busy_data", busy, 1);
            check("ar_valid_data", ar_valid, 0);
            @(posedge clk); #1;
            start = 1'b0;
            if (i == rw - 1) r_valid = 1'b1;
        end
        r_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("r_ready_done", r_ready, 0);
        last_data = d; last_resp = rs;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ar_valid"}, ar_valid, 0);
        check({tag, "_r_ready"}, r_ready, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ar_address"}, ar_address, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_resp"}, resp, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; addr = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        do_read(32'h0000_0040, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);
        do_read(32'h0000_0044, 5, 4, 32'h5555_AAAA, 2'b01, 1'b0);
        do_read(32'h0000_0040, 0, 2, 32'h0BAD_F00D, 2'b00, 1'b1);
        do_read(32'h0000_0048, 1, 0, 32'h0000_1234, 2'b10, 1'b0);
        do_read(32'h0000_004C, 0, 1, 32'h0000_A5A5, 2'b00, 1'b0);

        // Reset while waiting in DATA: everything clears and no done follows.
        @(posedge clk); #1;
        start = 1'b1; addr = 32'h100; ar_ready = 1'b1;
        arq.push_back(32'h100);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ar_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        last_data = '0; last_resp = '0;
        repeat (3) @(posedge clk);
        do_read(32'h0000_0050, 2, 1, 32'h7777_0001, 2'b11, 1'b0);

`ifdef READ_TIMEOUT_EN
        begin
            int   s;
            exp_t e;
            @(posedge clk); #1;
            s = cyc + 1;
            e.data = '0; e.resp = 2'b11; e.cyc = s + 16;
            sb.push_back(e);
            start = 1'b1; addr = 32'h200; ar_ready = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (15) @(posedge clk);
            @(negedge clk);
            check("to_ar_valid_before", ar_valid, 1);
            @(posedge clk);
            @(negedge clk);
            check("to_done", done, 1);
            check("to_ar_valid_after", ar_valid, 0);
            check("to_r_ready_after", r_ready, 0);
            check("to_busy_after", busy, 0);
            last_data = '0; last_resp = 2'b11;
        end
        do_read(32'h0000_0300, 0, 14, 32'h0000_CAFE, 2'b00, 1'b0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("arq_empty", arq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
